// File: rtl/data_memory_ls.sv
// Byte-addressable data memory for the load/store stage: lane-merged stores,
// sign/zero-extended loads, one-entry response buffer, misalignment detection.
module data_memory_ls #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned L      = $clog2(DATA_W / 8),
  localparam int unsigned ADDR_W = $clog2(DEPTH) + L
) (
  input  logic              Clock,
  input  logic              R,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              WriteEn,
  input  logic [ADDR_W-1:0] Addy,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [DATA_W-1:0] WriteData,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [DATA_W-1:0] ReadData,
  output logic              RespErr,
  output logic              MisalignErr
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_FULL = 2'b11
  } size_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic              misalign_err_q, misalign_err_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;

  logic [IW-1:0]     idx;
  logic [L-1:0]      off;
  size_e             size;
  logic              aligned;
  logic              accept;
  logic              sign_bit;
  logic [NB-1:0]     lane_mask, be;
  logic [DATA_W-1:0] keep_mask, wdata_sh, rword_sh, load_ext;

  assign idx      = Addy[ADDR_W-1:L];
  assign off      = Addy[L-1:0];
  assign size     = size_e'(Size);
  assign ReqReady = !resp_valid_q | RespReady;
  assign accept   = ReqValid & ReqReady;

  assign be       = lane_mask << off;
  assign wdata_sh = WriteData << {off, 3'b000};
  assign rword_sh = mem_q[idx] >> {off, 3'b000};

  always_comb begin
    aligned   = 1'b1;
    lane_mask = '1;
    keep_mask = '1;
    sign_bit  = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        lane_mask = NB'(1'b1);
        keep_mask = DATA_W'(8'hFF);
        sign_bit  = rword_sh[7];
      end
      SZ_HALF: begin
        aligned   = (off[0] == 1'b0);
        lane_mask = NB'(2'b11);
        keep_mask = DATA_W'(16'hFFFF);
        sign_bit  = rword_sh[15];
      end
      SZ_WORD: begin
        aligned   = (off[1:0] == 2'b00);
        lane_mask = NB'(4'hF);
        keep_mask = DATA_W'(32'hFFFF_FFFF);
        sign_bit  = rword_sh[31];
      end
      SZ_FULL: begin
        aligned   = (off == '0);
      end
    endcase
    // Full-width keep mask is all ones, so the fill term vanishes there.
    load_ext = (rword_sh & keep_mask) | ({DATA_W{sign_bit & !Unsigned}} & ~keep_mask);
  end

  always_comb begin
    mem_d          = mem_q;
    resp_valid_d   = resp_valid_q & !RespReady;
    read_data_d    = read_data_q;
    resp_err_d     = resp_err_q;
    misalign_err_d = misalign_err_q;
    if (accept && WriteEn) begin
      if (aligned) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (be[i]) mem_d[idx][8*i +: 8] = wdata_sh[8*i +: 8];
        end
      end else begin
        misalign_err_d = 1'b1;
      end
    end else if (accept) begin
      resp_valid_d = 1'b1;
      read_data_d  = aligned ? load_ext : '0;
      resp_err_d   = !aligned;
    end
  end

  always_ff @(posedge Clock or posedge R) begin
    if (R) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      resp_valid_q   <= 1'b0;
      read_data_q    <= '0;
      resp_err_q     <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      resp_valid_q   <= resp_valid_d;
      read_data_q    <= read_data_d;
      resp_err_q     <= resp_err_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign RespValid   = resp_valid_q;
  assign ReadData    = read_data_q;
  assign RespErr     = resp_err_q;
  assign MisalignErr = misalign_err_q;

endmodule

// File: tb/tb_data_memory_ls.sv
// Bench for data_memory_ls: vector table plus hand sequences, with a
// response scoreboard checked by a negedge monitor.
module tb_data_memory_ls;

  logic        Clock = 1'b0;
  logic        R;
  logic        ReqValid;
  logic        ReqReady;
  logic        WriteEn;
  logic [6:0]  Addy;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] WriteData;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] ReadData;
  logic        RespErr;
  logic        MisalignErr;

  data_memory_ls #(.DEPTH(32), .DATA_W(32)) dut (
    .Clock(Clock), .R(R), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .WriteEn(WriteEn), .Addy(Addy), .Size(Size), .Unsigned(Unsigned),
    .WriteData(WriteData), .RespValid(RespValid), .RespReady(RespReady),
    .ReadData(ReadData), .RespErr(RespErr), .MisalignErr(MisalignErr)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  vec_t  vecs[$];
  resp_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  acc = 1'b0;
  logic [31:0] cur_exp_data = '0;
  logic        cur_exp_err  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic we, input logic [6:0] a, input logic [1:0] sz,
                              input logic u, input logic [31:0] wd, input logic [31:0] ed,
                              input logic ee, input logic em);
    vec_t v;
    v.we = we; v.addr = a; v.size = sz; v.uns = u; v.wdata = wd;
    v.exp_data = ed; v.exp_err = ee; v.exp_mis = em;
    vecs.push_back(v);
  endfunction

  // Monitor: models RespValid/ReqReady from the scoreboard and logs acceptances.
  logic  had, exp_ready;
  resp_t r;
  always @(negedge Clock) begin
    if (R) begin
      acc = 1'b0;
    end else begin
      had       = (exp_q.size() != 0);
      exp_ready = !had | RespReady;
      check("resp_valid", 32'(RespValid), 32'(had));
      check("req_ready", 32'(ReqReady), 32'(exp_ready));
      if (had && RespReady) begin
        r = exp_q.pop_front();
        check("read_data", ReadData, r.data);
        check("resp_err", 32'(RespErr), 32'(r.err));
      end
      acc = ReqValid & exp_ready;
      if (acc && !WriteEn) begin
        r.data = cur_exp_data;
        r.err  = cur_exp_err;
        exp_q.push_back(r);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic we, input logic [6:0] a, input logic [1:0] sz,
                      input logic u, input logic [31:0] wd, input logic [31:0] ed,
                      input logic ee, output int cycles);
    WriteEn = we; Addy = a; Size = sz; Unsigned = u; WriteData = wd;
    cur_exp_data = ed; cur_exp_err = ee;
    ReqValid = 1'b1;
    cycles = 0;
    do begin
      @(posedge Clock); #1;
      cycles++;
    end while (!acc && cycles < 20);
    if (!acc) check("send_timeout", 32'(0), 32'(1));
    ReqValid = 1'b0;
  endtask

  task automatic drain();
    RespReady = 1'b1;
    ReqValid  = 1'b0;
    repeat (3) begin @(posedge Clock); #1; end
    check("queue_empty", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  int    cyc;
  logic  exp_mis;

  initial begin
    R = 1'b1; ReqValid = 1'b0; WriteEn = 1'b0; Addy = '0; Size = '0;
    Unsigned = 1'b0; WriteData = '0; RespReady = 1'b1;

    //   we  addr   size   u  wdata          exp_data       err  mis
    add(0, 7'h04, 2'b10, 0, 32'h0,         32'h0000_0000, 0, 0);
    add(1, 7'h08, 2'b10, 0, 32'hDEADBEEF,  32'h0,         0, 0);
    add(1, 7'h09, 2'b00, 0, 32'h0000_0011, 32'h0,         0, 0);
    add(0, 7'h08, 2'b10, 0, 32'h0,         32'hDEAD11EF,  0, 0);
    add(0, 7'h0B, 2'b00, 0, 32'h0,         32'hFFFFFFDE,  0, 0);
    add(0, 7'h0B, 2'b00, 1, 32'h0,         32'h000000DE,  0, 0);
    add(0, 7'h0A, 2'b01, 0, 32'h0,         32'hFFFFDEAD,  0, 0);
    add(0, 7'h0A, 2'b01, 1, 32'h0,         32'h0000DEAD,  0, 0);
    add(0, 7'h08, 2'b00, 0, 32'h0,         32'hFFFFFFEF,  0, 0);
    add(0, 7'h08, 2'b01, 0, 32'h0,         32'h000011EF,  0, 0);
    add(1, 7'h11, 2'b01, 0, 32'h0000_1234, 32'h0,         0, 1);
    add(0, 7'h10, 2'b10, 0, 32'h0,         32'h0000_0000, 0, 1);
    add(0, 7'h02, 2'b10, 0, 32'h0,         32'h0000_0000, 1, 1);
    add(0, 7'h09, 2'b01, 1, 32'h0,         32'h0000_0000, 1, 1);
    add(1, 7'h0E, 2'b01, 0, 32'h5555_ABCD, 32'h0,         0, 1);
    add(0, 7'h0C, 2'b10, 0, 32'h0,         32'hABCD0000,  0, 1);
    add(0, 7'h0E, 2'b01, 0, 32'h0,         32'hFFFFABCD,  0, 1);
    add(1, 7'h14, 2'b11, 0, 32'h8000_0001, 32'h0,         0, 1);
    add(0, 7'h14, 2'b11, 0, 32'h0,         32'h8000_0001, 0, 1);
    add(0, 7'h14, 2'b11, 1, 32'h0,         32'h8000_0001, 0, 1);
    add(0, 7'h16, 2'b11, 0, 32'h0,         32'h0000_0000, 1, 1);
    add(1, 7'h18, 2'b00, 0, 32'hFFFF_FF7F, 32'h0,         0, 1);
    add(0, 7'h18, 2'b10, 0, 32'h0,         32'h0000_007F, 0, 1);
    add(1, 7'h1F, 2'b10, 0, 32'h1111_1111, 32'h0,         0, 1);
    add(0, 7'h1C, 2'b10, 0, 32'h0,         32'h0000_0000, 0, 1);

    #3;
    check("rst_resp_valid", 32'(RespValid), 32'(0));
    check("rst_read_data", ReadData, 32'h0);
    check("rst_resp_err", 32'(RespErr), 32'(0));
    check("rst_misalign", 32'(MisalignErr), 32'(0));
    @(posedge Clock); #1;
    R = 1'b0;

    foreach (vecs[i]) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
           vecs[i].exp_data, vecs[i].exp_err, cyc);
      check($sformatf("misalign_v%0d", i), 32'(MisalignErr), 32'(vecs[i].exp_mis));
    end
    drain();

    // Stalled response blocks a following store until the take.
    RespReady = 1'b0;
    send(0, 7'h08, 2'b10, 0, 32'h0, 32'hDEAD11EF, 0, cyc);
    WriteEn = 1'b1; Addy = 7'h08; Size = 2'b10; WriteData = 32'hCAFEF00D;
    ReqValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clock); #1;
      check("stall_no_accept", 32'(acc), 32'(0));
      check("stall_hold_data", ReadData, 32'hDEAD11EF);
    end
    RespReady = 1'b1;
    @(posedge Clock); #1;
    check("store_after_take", 32'(acc), 32'(1));
    ReqValid = 1'b0;

    // Back-to-back loads must each be accepted in one cycle.
    send(0, 7'h08, 2'b10, 0, 32'h0, 32'hCAFEF00D, 0, cyc); check("b2b_0", 32'(cyc), 32'(1));
    send(0, 7'h04, 2'b10, 0, 32'h0, 32'h00000000, 0, cyc); check("b2b_1", 32'(cyc), 32'(1));
    send(0, 7'h08, 2'b00, 1, 32'h0, 32'h0000000D, 0, cyc); check("b2b_2", 32'(cyc), 32'(1));
    send(0, 7'h0A, 2'b01, 0, 32'h0, 32'hFFFFCAFE, 0, cyc); check("b2b_3", 32'(cyc), 32'(1));
    send(0, 7'h03, 2'b01, 0, 32'h0, 32'h00000000, 1, cyc); check("b2b_4", 32'(cyc), 32'(1));
    drain();

    // Asynchronous reset mid-cycle with a held response and a pending store.
    send(1, 7'h20, 2'b10, 0, 32'h55AA55AA, 32'h0, 0, cyc);
    RespReady = 1'b0;
    send(0, 7'h20, 2'b10, 0, 32'h0, 32'h55AA55AA, 0, cyc);
    WriteEn = 1'b1; Addy = 7'h24; Size = 2'b10; WriteData = 32'h0000_0001;
    ReqValid = 1'b1;
    #2;
    R = 1'b1;
    #1;
    exp_q.delete();
    check("async_resp_valid", 32'(RespValid), 32'(0));
    check("async_read_data", ReadData, 32'h0);
    check("async_misalign", 32'(MisalignErr), 32'(0));
    ReqValid = 1'b0; RespReady = 1'b1;
    @(posedge Clock); #1;
    R = 1'b0;
    exp_mis = 1'b0;
    send(0, 7'h20, 2'b10, 0, 32'h0, 32'h0, 0, cyc);
    send(0, 7'h24, 2'b10, 0, 32'h0, 32'h0, 0, cyc);
    send(0, 7'h08, 2'b10, 0, 32'h0, 32'h0, 0, cyc);
    send(0, 7'h14, 2'b11, 0, 32'h0, 32'h0, 0, cyc);
    check("post_rst_misalign", 32'(MisalignErr), 32'(exp_mis));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ls.md
Name: data_memory_ls

Overview:
Parametrised byte-addressable data memory for the datapath's load/store stage. It supports byte, halfword, word and full-width accesses with byte-lane write merging, and sign- or zero-extension on loads. Requests use a valid/ready handshake and load data comes back from a one-entry registered response buffer with backpressure. Misaligned accesses are detected: misaligned loads return an error response, and misaligned stores are dropped and recorded in a sticky error flag.

Parameters:
DEPTH, 32, number of words; power of 2, >= 2
DATA_W, 32, word width in bits; multiple of 8, >= 32
ADDR_W (localparam), $clog2(DEPTH)+$clog2(DATA_W/8), byte-address width

Ports:
Clock  in  1  system clock, rising edge
R  in  1  reset, asynchronous, active-high
ReqValid  in  1  request present
ReqReady  out  1  request accepted when ReqValid & ReqReady at a rising edge
WriteEn  in  1  1 = store, 0 = load
Addy  in  ADDR_W  byte address
Size  in  2  access size: 00 byte, 01 half (16b), 10 word (32b), 11 full DATA_W
Unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
WriteData  in  DATA_W  store data, right-justified (bits [8*n-1:0] used)
RespValid  out  1  load response held in buffer
RespReady  in  1  consumer takes response when RespValid & RespReady at a rising edge
ReadData  out  DATA_W  load result
RespErr  out  1  response belongs to a misaligned load
MisalignErr  out  1  sticky: a misaligned store was dropped

Behaviour:
- Clock and reset: single clock Clock; reset R is asynchronous and active-high.
- Reset (async): all DEPTH words cleared to 0. RespValid=0, ReadData=0, RespErr=0, MisalignErr=0.
- Reset mid-operation: any pending response is discarded, and any in-flight store is not written.
- Word index = Addy[ADDR_W-1:L], where L = $clog2(DATA_W/8). Lane offset = Addy[L-1:0].
- Alignment: byte is always aligned. Half requires offset[0]=0. Word requires offset[1:0]=0. Full requires offset=0.
- ReqReady = !RespValid | RespReady (combinational). A stalled response blocks stores as well, so request order is preserved.
- Store, accepted and aligned: on the accepting edge, only the addressed byte lanes are written; all other lanes are unchanged.
  - Byte: 1 lane.
  - Half: 2 lanes.
  - Word: 4 lanes.
  - Full: all lanes.
- Stores produce no response.
- Store, accepted and misaligned: memory is unchanged and MisalignErr is set to 1. It stays 1 until reset.
- Load, accepted: on the accepting edge, the response register loads and RespValid goes to 1. Latency is 1 cycle from acceptance to RespValid.
  - Aligned load: the selected field is extended to DATA_W and loaded into ReadData; RespErr=0.
  - Misaligned load: ReadData=0 and RespErr=1.
  - Extension: zero-extend when Unsigned=1, sign-extend from the field MSB when Unsigned=0.
  - Full-size loads ignore Unsigned. Word loads with DATA_W=32 ignore extension.
- Response buffer:
  - RespValid & !RespReady: ReadData and RespErr are held stable.
  - RespValid & RespReady with no new load accepted: RespValid goes to 0 at the edge; ReadData keeps its last value.
  - Take and new load accepted in the same cycle: the buffer is overwritten; there is no bubble, so full throughput is 1 load per cycle.
- Read-after-write: a load accepted the cycle after a store to the same word returns the post-store contents. No same-edge forwarding is needed because only one request is accepted per cycle.
- Addy always maps inside the array (DEPTH is a power of 2), so there is no out-of-range case.
- ReqValid=0: memory and response state are unchanged, apart from the take rule above.

Test Plan:
- Reset, then load word @0x04, RespReady=1 -> RespValid=1 one cycle after acceptance; ReadData=0x00000000, RespErr=0.
- Store word 0xDEADBEEF @0x08; store byte 0x11 @0x09; load word @0x08 -> ReadData=0xDEAD11EF.
- Using the word from the previous case: load byte @0x0B, Unsigned=0 -> 0xFFFFFFDE; Unsigned=1 -> 0x000000DE. Load half @0x0A, Unsigned=0 -> 0xFFFFDEAD.
- Store half 0x1234 @0x11 -> MisalignErr=1 and word @0x10 still 0. Load word @0x02 -> RespValid=1, RespErr=1, ReadData=0.
- Load @0x08 with RespReady=0 for 3 cycles -> ReqReady=0, a concurrent store @0x08 is not accepted, and ReadData is held. Raise RespReady -> the store is accepted the same cycle; a back-to-back load stream then gives 1 response/cycle.
- Store @0x20 then assert R asynchronously mid-cycle with RespValid=1 -> RespValid=0, MisalignErr=0 and all words read 0 after release.
